// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Control FSM for the shared-memory multicycle MIPS datapath. One memory
//   port serves instruction fetch and data access. Opcode/funct are decoded
//   from the instruction register, and the datapath strobes and muxes are
//   driven from the current state. The block also provides a memory-ready
//   wait handshake, a sticky watchdog flag and an illegal-instruction pulse.
//
//   Parameters: MAX_WAIT  consecutive not-ready cycles before mem_timeout (1..255)
//               WAIT_W    wait counter width
//   Inputs : clk, reset (sync, active-high), op, funct, zero, mem_ready
//   Outputs: memwrite, irwrite, pcen, regwrite, iord, memtoreg, regdst,
//            alusrca, alusrcb, pcsrc, alucontrol, state (debug),
//            instr_done, illegal_op (1-cycle pulse), mem_timeout (sticky)
//
//   Build option: define MC_BNE_EN to decode op 000101 (bne) as a branch
//   taken when zero=0. Without it, bne is treated as an illegal opcode.
module mips_multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_MAX_M1 = WAIT_W'(MAX_WAIT - 1);

  state_t            st;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_now;
  logic              is_branch;
  logic              br_take;
  logic              f_ok;
  logic [2:0]        f_alu;

  assign state = st;

  // A wait cycle is any not-ready cycle in a state that owns the memory port.
  assign wait_now = ((st == FETCH) || (st == MEMRD) || (st == MEMWR)) && !mem_ready;

`ifdef MC_BNE_EN
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign br_take   = (op == OP_BNE) ? ~zero : zero;
`else
  assign is_branch = (op == OP_BEQ);
  assign br_take   = zero;
`endif

  always_comb begin
    f_ok  = 1'b1;
    f_alu = ALU_ADD;
    case (funct)
      6'b100000: f_alu = ALU_ADD;
      6'b100010: f_alu = ALU_SUB;
      6'b100100: f_alu = ALU_AND;
      6'b100101: f_alu = ALU_OR;
      6'b101010: f_alu = ALU_SLT;
      default:   f_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= FETCH;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      illegal_op <= 1'b0;

      // The FSM cannot leave a memory state while not ready, so clearing on
      // any non-wait cycle also covers the "left the state" case.
      if (wait_now) begin
        if (wait_cnt != WAIT_MAX)
          wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (wait_now && (wait_cnt == WAIT_MAX_M1))
        mem_timeout <= 1'b1;

      case (st)
        FETCH:   if (mem_ready) st <= DECODE;
        DECODE: begin
          if ((op == OP_LW) || (op == OP_SW)) st <= MEMADR;
          else if (op == OP_RTYPE)            st <= EXECUTE;
          else if (is_branch)                 st <= BRANCH;
          else if (op == OP_ADDI)             st <= ADDIEXEC;
          else if (op == OP_J)                st <= JUMP;
          else begin
            st         <= FETCH;
            illegal_op <= 1'b1;
          end
        end
        MEMADR:  st <= (op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (mem_ready) st <= MEMWB;
        MEMWR:   if (mem_ready) st <= FETCH;
        EXECUTE: begin
          if (f_ok) begin
            st <= ALUWB;
          end else begin
            st         <= FETCH;
            illegal_op <= 1'b1;
          end
        end
        ADDIEXEC: st <= ADDIWB;
        default:  st <= FETCH;
      endcase
    end
  end

  always_comb begin
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    instr_done = 1'b0;
    case (st)
      FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = mem_ready;
        pcen       = mem_ready;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = f_alu;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = br_take;
        instr_done = 1'b1;
      end
      ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
